// File: rtl/sat_event_monitor.sv
// Saturation event monitor: passes samples through, counts overflow/underflow
// events, and raises irq when a window's event count reaches a threshold.
// Optional peak |data_in| tracking is built when SAT_MON_PEAK_EN is defined.
module sat_event_monitor #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int WIN_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         valid_in,
  input  logic                         overflow_in,
  input  logic                         underflow_in,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [WIN_WIDTH-1:0]         win_len,
  input  logic [WIN_WIDTH-1:0]         threshold,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid_out,
  output logic [CNT_WIDTH-1:0]         ovf_count,
  output logic [CNT_WIDTH-1:0]         udf_count,
  output logic                         ovf_sticky,
  output logic                         udf_sticky,
  output logic                         irq,
  output logic [DATA_WIDTH-1:0]        peak_abs,
  output logic [1:0]                   state_dbg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ALARM = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [WIN_WIDTH-1:0]  win_cnt_q, win_cnt_d;
  logic [WIN_WIDTH-1:0]  win_evt_q, win_evt_d;
  logic [WIN_WIDTH:0]    samp_nxt;
  logic [WIN_WIDTH-1:0]  evt_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic [CNT_WIDTH-1:0]  ovf_cnt_q, ovf_cnt_d, udf_cnt_q, udf_cnt_d;
  logic                  ovf_st_q, ovf_st_d, udf_st_q, udf_st_d;
  logic                  ovf_evt, udf_evt, any_evt;

  assign ovf_evt = valid_in & overflow_in;
  assign udf_evt = valid_in & underflow_in;
  assign any_evt = ovf_evt | udf_evt;

  // Totals and sticky flags run independently of enable; clear drops a
  // coincident event.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    udf_cnt_d = udf_cnt_q;
    ovf_st_d  = ovf_st_q;
    udf_st_d  = udf_st_q;
    if (clear) begin
      ovf_cnt_d = '0;
      udf_cnt_d = '0;
      ovf_st_d  = 1'b0;
      udf_st_d  = 1'b0;
    end else begin
      if (ovf_evt) begin
        ovf_st_d = 1'b1;
        if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
      end
      if (udf_evt) begin
        udf_st_d = 1'b1;
        if (udf_cnt_q != '1) udf_cnt_d = udf_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    win_evt_d = win_evt_q;
    samp_nxt  = {1'b0, win_cnt_q} + 1'b1;
    evt_nxt   = (any_evt && win_evt_q != '1) ? win_evt_q + 1'b1 : win_evt_q;
    case (state_q)
      ST_IDLE: begin
        win_cnt_d = '0;
        win_evt_d = '0;
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          win_cnt_d = '0;
          win_evt_d = '0;
        end else if (clear || win_len == '0) begin
          win_cnt_d = '0;
          win_evt_d = '0;
        end else if (valid_in) begin
          // >= so a shrunken win_len closes the window on the next sample.
          if (samp_nxt >= {1'b0, win_len}) begin
            win_cnt_d = '0;
            win_evt_d = '0;
            if (evt_nxt >= threshold) state_d = ST_ALARM;
          end else begin
            win_cnt_d = samp_nxt[WIN_WIDTH-1:0];
            win_evt_d = evt_nxt;
          end
        end
      end
      ST_ALARM: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          win_cnt_d = '0;
          win_evt_d = '0;
        end else if (clear) begin
          state_d   = ST_RUN;
          win_cnt_d = '0;
          win_evt_d = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        win_cnt_d = '0;
        win_evt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      win_cnt_q <= '0;
      win_evt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
      ovf_st_q  <= 1'b0;
      udf_st_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      win_evt_q <= win_evt_d;
      data_q    <= valid_in ? data_in : '0;
      valid_q   <= valid_in;
      ovf_cnt_q <= ovf_cnt_d;
      udf_cnt_q <= udf_cnt_d;
      ovf_st_q  <= ovf_st_d;
      udf_st_q  <= udf_st_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign ovf_count  = ovf_cnt_q;
  assign udf_count  = udf_cnt_q;
  assign ovf_sticky = ovf_st_q;
  assign udf_sticky = udf_st_q;
  assign irq        = (state_q == ST_ALARM);
  assign state_dbg  = state_q;

`ifdef SAT_MON_PEAK_EN
  logic [DATA_WIDTH-1:0] abs_in, peak_q;
  // Two's-complement negate of the most-negative value yields 2^(W-1) unsigned.
  assign abs_in = data_in[DATA_WIDTH-1] ? DATA_WIDTH'(~data_in + 1'b1) : data_in;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) peak_q <= '0;
    else if (valid_in && abs_in > peak_q) peak_q <= abs_in;
  end

  assign peak_abs = peak_q;
`else
  assign peak_abs = '0;
`endif

endmodule

// File: tb/tb_sat_event_monitor.sv
// Directed self-checking bench for sat_event_monitor (CNT_WIDTH=4 instance).
module tb_sat_event_monitor;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int WW = 16;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_ALARM = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          valid_in, overflow_in, underflow_in, enable, clear;
  logic [WW-1:0] win_len, threshold;
  logic [DW-1:0] data_out, peak_abs;
  logic          valid_out, ovf_sticky, udf_sticky, irq;
  logic [CW-1:0] ovf_count, udf_count;
  logic [1:0]    state_dbg;

  int tests = 0;
  int fails = 0;

  sat_event_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .WIN_WIDTH(WW)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .overflow_in(overflow_in), .underflow_in(underflow_in), .enable(enable),
    .clear(clear), .win_len(win_len), .threshold(threshold),
    .data_out(data_out), .valid_out(valid_out), .ovf_count(ovf_count),
    .udf_count(udf_count), .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky),
    .irq(irq), .peak_abs(peak_abs), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [DW-1:0] d, input logic o, input logic u);
    valid_in = 1'b1; data_in = d; overflow_in = o; underflow_in = u;
    step();
    valid_in = 1'b0; overflow_in = 1'b0; underflow_in = 1'b0;
  endtask

  initial begin
    // Reset with active inputs
    rst_n = 1'b0; data_in = 16'h1234; valid_in = 1'b1; overflow_in = 1'b1;
    underflow_in = 1'b0; enable = 1'b1; clear = 1'b0; win_len = 16'd4; threshold = 16'd2;
    step(); step();
    chk("rst_data_out", data_out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_ovf_count", ovf_count, 0);
    chk("rst_ovf_sticky", ovf_sticky, 0);
    chk("rst_irq", irq, 0);
    chk("rst_state", state_dbg, S_IDLE);
    chk("rst_peak", peak_abs, 0);

    // Pass-through while disabled
    rst_n = 1'b1; enable = 1'b0; valid_in = 1'b0; overflow_in = 1'b0;
    sample(16'h7FFF, 0, 0);
    chk("pt_7fff", data_out, 16'h7FFF);
    chk("pt_valid", valid_out, 1);
    sample(16'h8000, 0, 0);
    chk("pt_8000", data_out, 16'h8000);
    sample(16'h0001, 0, 0);
    chk("pt_0001", data_out, 16'h0001);
    data_in = 16'h5555; step();
    chk("pt_invalid_zero", data_out, 0);
    chk("pt_invalid_valid", valid_out, 0);
    chk("pt_idle", state_dbg, S_IDLE);

    // Alarm: win_len 4, threshold 2, events on samples 2 and 4
    enable = 1'b1; step();
    chk("al_run", state_dbg, S_RUN);
    sample(16'h0010, 0, 0);
    sample(16'h7FFF, 1, 0);
    chk("al_irq_mid", irq, 0);
    sample(16'h0020, 0, 0);
    sample(16'h7FFF, 1, 0);
    chk("al_irq", irq, 1);
    chk("al_state", state_dbg, S_ALARM);
    chk("al_ovf2", ovf_count, 2);
    step(); step();
    chk("al_hold", irq, 1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("al_clr_irq", irq, 0);
    chk("al_clr_ovf", ovf_count, 0);
    chk("al_clr_udf", udf_count, 0);
    chk("al_clr_sticky", ovf_sticky, 0);
    chk("al_clr_state", state_dbg, S_RUN);

    // No alarm: threshold 3, two events per window, three windows
    threshold = 16'd3;
    for (int w = 0; w < 3; w++) begin
      sample(16'h7FFF, 1, 0);
      sample(16'h0001, 0, 0);
      sample(16'h7FFF, 1, 0);
      sample(16'h0002, 0, 0);
      chk("na_irq", irq, 0);
    end
    chk("na_ovf6", ovf_count, 6);

    // threshold 0 alarms at a window end with no events
    threshold = 16'd0;
    for (int i = 0; i < 3; i++) sample(16'h0003, 0, 0);
    chk("t0_irq_mid", irq, 0);
    sample(16'h0003, 0, 0);
    chk("t0_irq", irq, 1);
    enable = 1'b0; step();
    chk("dis_idle", state_dbg, S_IDLE);
    chk("dis_irq", irq, 0);
    chk("dis_keep_ovf", ovf_count, 6);
    chk("dis_keep_sticky", ovf_sticky, 1);

    // win_len 0 disables evaluation
    enable = 1'b1; win_len = 16'd0; step();
    for (int i = 0; i < 6; i++) sample(16'h0004, 1, 0);
    chk("wl0_irq", irq, 0);
    chk("wl0_state", state_dbg, S_RUN);

    // Counter boundaries (disabled so no alarm)
    enable = 1'b0; clear = 1'b1; step(); clear = 1'b0;
    chk("bd_clr", ovf_count, 0);
    sample(16'h0000, 1, 1);
    chk("bd_both_ovf", ovf_count, 1);
    chk("bd_both_udf", udf_count, 1);
    chk("bd_both_udf_sticky", udf_sticky, 1);
    valid_in = 1'b0; overflow_in = 1'b1; step(); overflow_in = 1'b0;
    chk("bd_novalid", ovf_count, 1);
    for (int i = 0; i < 20; i++) sample(16'h7FFF, 1, 0);
    chk("bd_sat", ovf_count, 15);
    chk("bd_udf_kept", udf_count, 1);
    clear = 1'b1; valid_in = 1'b1; overflow_in = 1'b1; underflow_in = 1'b1;
    step();
    clear = 1'b0; valid_in = 1'b0; overflow_in = 1'b0; underflow_in = 1'b0;
    chk("bd_clr_evt_ovf", ovf_count, 0);
    chk("bd_clr_evt_udf", udf_count, 0);
    chk("bd_clr_evt_sticky", ovf_sticky, 0);

    // Peak magnitude
    sample(16'd100, 0, 0);
`ifdef SAT_MON_PEAK_EN
    chk("pk_100", peak_abs, 100);
    sample(16'hFED4, 0, 0);
    chk("pk_300", peak_abs, 300);
    sample(16'h8000, 0, 0);
    chk("pk_8000", peak_abs, 16'h8000);
    sample(16'd50, 0, 0);
    chk("pk_hold", peak_abs, 16'h8000);
    clear = 1'b1; step(); clear = 1'b0;
    chk("pk_clr", peak_abs, 0);
`else
    chk("pk_off_100", peak_abs, 0);
    sample(16'h8000, 0, 0);
    chk("pk_off_8000", peak_abs, 0);
`endif

    // Reset mid-window discards the partial window
    enable = 1'b1; win_len = 16'd4; threshold = 16'd1; step();
    sample(16'h0005, 1, 0);
    sample(16'h0005, 1, 0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mr_state", state_dbg, S_IDLE);
    chk("mr_ovf", ovf_count, 0);
    step();
    chk("mr_run", state_dbg, S_RUN);
    sample(16'h0006, 0, 0);
    sample(16'h0006, 0, 0);
    chk("mr_irq_s2", irq, 0);
    sample(16'h0006, 0, 0);
    chk("mr_irq_s3", irq, 0);
    sample(16'h0006, 1, 0);
    chk("mr_irq_s4", irq, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sat_event_monitor.md
SAT_EVENT_MONITOR -- requirements
Module: sat_event_monitor

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, as the sample width (signed Q1.15 at default).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, as the width of the total event counters.
REQ-003 The block SHALL have parameter WIN_WIDTH, default 16, as the width of the window length, threshold and window counters.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 data_in  input  DATA_WIDTH  signed sample from the rounding/saturation stage.
REQ-007 valid_in  input  1  data_in, overflow_in and underflow_in qualified.
REQ-008 overflow_in  input  1  sample was clipped to the positive maximum.
REQ-009 underflow_in  input  1  sample was clipped to the negative minimum.
REQ-010 enable  input  1  monitor enable.
REQ-011 clear  input  1  synchronous clear of counters, sticky flags, peak and alarm.
REQ-012 win_len  input  WIN_WIDTH  valid samples per measurement window.
REQ-013 threshold  input  WIN_WIDTH  in-window event count that raises the alarm.
REQ-014 data_out  output  DATA_WIDTH  registered copy of data_in.
REQ-015 valid_out  output  1  registered copy of valid_in.
REQ-016 ovf_count / udf_count  output  CNT_WIDTH each  saturating total overflow / underflow counts.
REQ-017 ovf_sticky / udf_sticky  output  1 each  an event of that type has occurred since the last clear.
REQ-018 irq  output  1  alarm; high exactly while the FSM is in ALARM.
REQ-019 peak_abs  output  DATA_WIDTH  largest |data_in| seen since the last clear (REQ-036).

Function
REQ-020 data_out/valid_out SHALL have 1-cycle latency; data_out SHALL load data_in when valid_in=1 and load 0 when valid_in=0; pass-through SHALL be independent of enable.
REQ-021 An event SHALL be a cycle with valid_in=1 and (overflow_in or underflow_in); flags without valid_in SHALL be ignored.
REQ-022 Total counters and sticky flags SHALL update on events regardless of enable; each counter SHALL stop at all-ones with no wrap-around.
REQ-023 If overflow_in and underflow_in are both high on a valid cycle, both counters and both sticky flags SHALL update, and it SHALL count as one window event.
REQ-024 The FSM SHALL have states IDLE, RUN and ALARM.
REQ-025 IDLE: window sample counter and window event counter held at 0; enable=1 SHALL move to RUN on the next edge.
REQ-026 RUN: each valid sample SHALL increment the window sample counter, and each event SHALL increment the window event counter, which saturates.
REQ-027 Window end SHALL be the valid sample that brings the sample count to win_len; that sample's event SHALL be included; both window counters SHALL restart from 0 on the next cycle.
REQ-028 At window end, if the window event count including that sample is >= threshold, the FSM SHALL enter ALARM; otherwise it SHALL stay in RUN; threshold=0 SHALL therefore alarm at every window end.
REQ-029 win_len=0 SHALL disable window evaluation: the FSM stays in RUN, the window counters hold at 0, and no alarm is raised.
REQ-030 ALARM SHALL be held, with window counting frozen, until clear=1 or enable=0.
REQ-031 enable=0 in RUN or ALARM SHALL return the FSM to IDLE on the next edge and zero the window counters; totals and sticky flags SHALL be kept.
REQ-032 clear=1 SHALL zero the totals, sticky flags, peak_abs and window counters, and move ALARM to RUN (enable=1) or IDLE (enable=0); an event in the same cycle as clear SHALL be dropped (clear wins).
REQ-033 win_len or threshold changes SHALL take effect on the next evaluated sample; the window counters SHALL NOT be reset by such a change.

Reset
REQ-034 On rst_n=0 at a clock edge, all outputs and counters SHALL go to 0 and the FSM to IDLE, regardless of the other inputs.
REQ-035 Reset asserted mid-window SHALL discard the partial window; after reset, the first window SHALL begin on the first valid sample following entry to RUN.

Configuration
REQ-036 With macro SAT_MON_PEAK_EN defined, peak_abs SHALL track the maximum |data_in| over valid samples; |most-negative| SHALL map to 2^(DATA_WIDTH-1) held unsigned; peak_abs SHALL be cleared by clear/reset and updated regardless of enable.
REQ-037 Without SAT_MON_PEAK_EN, the port SHALL exist and be driven constant 0, with no peak logic synthesized.

Verification
REQ-038 Reset: rst_n=0 for 2 cycles with valid_in=1, overflow_in=1 -> all outputs 0 and the FSM in IDLE.
REQ-039 Pass-through: valid samples 0x7FFF, 0x8000, 0x0001 -> identical data_out one cycle later; valid_in=0 -> data_out=0.
REQ-040 Alarm: enable=1, win_len=4, threshold=2, events on samples 2 and 4 -> irq=1 the cycle after sample 4; clear -> irq=0, both counts 0, FSM in RUN.
REQ-041 No alarm: win_len=4, threshold=3, 2 events per window for 3 windows -> irq stays 0, ovf_count=6.
REQ-042 Boundaries: CNT_WIDTH=4, 20 overflow events -> ovf_count=15; overflow_in and underflow_in together -> both counts +1; clear in the same cycle as an event -> that count stays 0.
REQ-043 Peak (SAT_MON_PEAK_EN defined): samples 100, -300, 0x8000 -> peak_abs 100, 300, 0x8000; without the macro, peak_abs stays 0.
